// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths:
// frame constants, the receiver FSM state encoding and a parity helper.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Even parity bit for a data byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous uart_rx line.
// Flops reset to the idle line level so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_line,
  output logic rx_synced
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift the raw line through the flop chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_r <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], rx_line};
    end
  end

  assign rx_synced = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_receiver.sv
// UART receive stage: oversamples uart_rx, recovers 8N1 frames LSB first and
// hands each byte over through a valid/ack holding register. Framing errors
// and overruns are reported as one-clk pulses.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 uart_rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  rx_state_t            state_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r;
`endif

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_line   (uart_rx),
    .rx_synced (rx_s)
  );

  assign rx_busy = (state_r != IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Frame FSM, bit/tick counters, shift register and the handshake holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      bit_cnt_r  <= 3'd0;
      shreg_r    <= {DATA_BITS{1'b0}};
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad_r  <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A consumer ack clears the holding register; a delivery below overrides it.
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
      if (sample_en) begin
        case (state_r)
          IDLE: begin
            if (rx_s == START_BIT) begin
              state_r    <= START;
              tick_cnt_r <= TICK_ZERO;
            end
          end
          START: begin
            if (tick_cnt_r == TICK_HALF) begin
              // Mid start bit: a high line here was only a glitch.
              tick_cnt_r <= TICK_ZERO;
              bit_cnt_r  <= 3'd0;
              state_r    <= (rx_s == START_BIT) ? DATA : IDLE;
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
          DATA: begin
            if (tick_cnt_r == TICK_LAST) begin
              shreg_r    <= {rx_s, shreg_r[DATA_BITS-1:1]};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              tick_cnt_r <= TICK_ZERO;
              if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt_r == TICK_LAST) begin
              par_bad_r  <= (even_parity(shreg_r) != rx_s);
              tick_cnt_r <= TICK_ZERO;
              state_r    <= STOP;
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
`endif
          STOP: begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_r <= TICK_ZERO;
              if (rx_s == STOP_BIT) begin
                state_r <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_bad_r) begin
                  parity_err <= 1'b1;
                end else begin
                  rx_data  <= shreg_r;
                  rx_valid <= 1'b1;
                  overrun  <= rx_valid & ~rx_ack;
                end
`else
                rx_data  <= shreg_r;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ack;
`endif
              end else begin
                // Stop bit low: drop the byte and wait for the line to recover.
                frame_err <= 1'b1;
                state_r   <= BREAK;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad_r;
`endif
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
          BREAK: begin
            if (rx_s == IDLE_LEVEL) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r    <= IDLE;
            tick_cnt_r <= TICK_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: OVERSAMPLE=16, sample_en every 4th clk.
// Define UART_RX_PARITY_EN for both RTL and bench to exercise 8E1 frames.
module tb_uart_byte_receiver;

  localparam int BIT_CLKS = 16 * 4;
`ifdef UART_RX_PARITY_EN
  localparam int DELIV_STROBE = 168;
`else
  localparam int DELIV_STROBE = 152;
`endif

  logic       clk;
  logic       reset;
  logic       sample_en;
  logic       uart_rx;
  logic       rx_ack;
  logic       ack_man;
  logic       ack_auto;
  logic       arm_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int deliv_cnt = 0;
  logic [7:0] exp_q[$];

  assign rx_ack = ack_man | ack_auto;

  uart_byte_receiver #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .uart_rx    (uart_rx),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Baud strobe plus a one-cycle ack aimed exactly at the delivery edge of an armed frame.
  initial begin : strobe_gen
    int div = 0;
    int strobe_cnt = 0;
    bit armed = 1'b0;
    bit done = 1'b0;
    sample_en = 1'b0;
    ack_auto  = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      sample_en = (div == 0);
      ack_auto = 1'b0;
      if (!arm_req) done = 1'b0;
      if (arm_req && !armed && !done && rx_busy) begin
        armed = 1'b1;
        strobe_cnt = 0;
      end
      if (armed && sample_en) begin
        strobe_cnt++;
        if (strobe_cnt == DELIV_STROBE) begin
          ack_auto = 1'b1;
          armed = 1'b0;
          done = 1'b1;
        end
      end
    end
  end

  // Monitor: counts pulse cycles and compares every delivered byte with the scoreboard.
  initial begin : monitor
    logic       prev_valid;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
        prev_data  = 8'h00;
      end else begin
        fe_cnt += int'(frame_err);
        ov_cnt += int'(overrun);
        pe_cnt += int'(parity_err);
        if (rx_valid && (!prev_valid || rx_data != prev_data)) begin
          deliv_cnt++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got %0h, expected no delivery", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", {24'h0, rx_data}, {24'h0, e});
          end
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
      end
    end
  end

  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      uart_rx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  // One frame; stop is the stop-bit level, par only used for 8E1.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
    send_bits({1'b0, stop, par, d, 1'b0}, 11);
`else
    send_bits({2'b00, stop, d, 1'b0}, 10);
    if (par) begin
      uart_rx = stop;
    end
`endif
    if (stop) begin
      uart_rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (rx_busy && k < max) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'h0, rx_busy}, 32'h0);
  endtask

  task automatic pulse_ack();
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset   = 1'b0;
    uart_rx = 1'b1;
    ack_man = 1'b0;
    arm_req = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data",  {24'h0, rx_data}, 32'h0);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_busy",  {31'h0, rx_busy}, 32'h0);
    check("rst_pulses", {29'h0, frame_err, overrun, parity_err}, 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // 1: clean frame then ack
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_idle("t1_idle", 200);
    check("t1_valid", {31'h0, rx_valid}, 32'h1);
    check("t1_data",  {24'h0, rx_data}, 32'hA5);
    check("t1_fe",    fe_cnt, 32'd0);
    pulse_ack();
    check("t1_ack_clears", {31'h0, rx_valid}, 32'h0);

    // 2: short low glitch on an idle line
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    check("t2_busy_in_start", {31'h0, rx_busy}, 32'h1);
    wait_idle("t2_idle", 200);
    repeat (BIT_CLKS) @(negedge clk);
    check("t2_valid", {31'h0, rx_valid}, 32'h0);
    check("t2_errs",  fe_cnt + ov_cnt + pe_cnt, 32'd0);
    check("t2_deliv", deliv_cnt, 32'd1);

    // 3: bad stop bit, line held low, then released
    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (BIT_CLKS) @(negedge clk);
    check("t3_fe_pulse", fe_cnt, 32'd1);
    check("t3_break_busy", {31'h0, rx_busy}, 32'h1);
    uart_rx = 1'b1;
    wait_idle("t3_break_exit", 40);
    check("t3_valid", {31'h0, rx_valid}, 32'h0);
    check("t3_deliv", deliv_cnt, 32'd1);

    // 4: two frames without ack, then a delivery coinciding with ack
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, ^8'h22);
    wait_idle("t4_idle", 200);
    check("t4_data",    {24'h0, rx_data}, 32'h22);
    check("t4_overrun", ov_cnt, 32'd1);
    check("t4_valid",   {31'h0, rx_valid}, 32'h1);
    arm_req = 1'b1;
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b1, ^8'h44);
    wait_idle("t4b_idle", 200);
    arm_req = 1'b0;
    check("t4b_no_overrun", ov_cnt, 32'd1);
    check("t4b_valid", {31'h0, rx_valid}, 32'h1);
    check("t4b_data",  {24'h0, rx_data}, 32'h44);
    pulse_ack();
    check("t4b_ack_clears", {31'h0, rx_valid}, 32'h0);

    // 5: reset during data bit 4 of 0x5A, then a clean 0xC3
    send_bits({2'b00, 1'b1, 8'h5A, 1'b0}, 5);
    uart_rx = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err}, 32'h0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("t5_no_partial", {31'h0, rx_valid}, 32'h0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    wait_idle("t5_idle", 200);
    check("t5_data",  {24'h0, rx_data}, 32'hC3);
    check("t5_valid", {31'h0, rx_valid}, 32'h1);
    check("t5_deliv", deliv_cnt, 32'd5);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_idle("t6_idle", 200);
    check("t6_valid", {31'h0, rx_valid}, 32'h1);
    check("t6_pe_none", pe_cnt, 32'd0);
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b0);
    wait_idle("t6b_idle", 200);
    check("t6b_pe_pulse", pe_cnt, 32'd1);
    check("t6b_dropped", {31'h0, rx_valid}, 32'h0);
    check("t6b_deliv", deliv_cnt, 32'd6);
`else
    check("parity_err_tied", pe_cnt, 32'd0);
`endif

    repeat (20) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
